// File: rtl/distance_constraint_solver.sv
// Fix-constraint solver for one rope segment: moves nodes A and B toward the
// rest length using an iterative square root and restoring divider (51-cycle latency).
module distance_constraint_solver #(
  parameter logic signed [31:0] REST_LEN = 32'h0000A000,
  parameter int                 FRAC     = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        pin_a_i,
  input  logic        pin_b_i,
  input  logic [31:0] xa_i,
  input  logic [31:0] ya_i,
  input  logic [31:0] xb_i,
  input  logic [31:0] yb_i,
  output logic [31:0] xa_fix_o,
  output logic [31:0] ya_fix_o,
  output logic [31:0] xb_fix_o,
  output logic [31:0] yb_fix_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DELTA = 3'd1;
  localparam logic [2:0] SQSUM = 3'd2;
  localparam logic [2:0] SQRT  = 3'd3;
  localparam logic [2:0] DIV   = 3'd4;
  localparam logic [2:0] APPLY = 3'd5;
  localparam int DIV_ITERS = 16;

  logic [2:0]  state_q;
  logic [4:0]  cnt_q;
  logic        busy_q, done_q, pinA_q, pinB_q;
  logic [31:0] xa_q, ya_q, xb_q, yb_q;
  logic [31:0] dx_q, dy_q;
  logic [63:0] sqSrc_q;
  logic [33:0] sqRem_q;
  logic [31:0] sqRoot_q;
  logic [63:0] divRem_q, divDen_q;
  logic [15:0] quo_q;
  logic        neg_q, dZero_q, clamp_q;
  logic [31:0] xaFix_q, yaFix_q, xbFix_q, ybFix_q;

  logic [63:0] sqSum_d;
  logic [35:0] remShift, trial, sqRem_d;
  logic [31:0] sqRoot_d;
  logic [32:0] diff, mag;
  logic [63:0] divRem_d;
  logic [15:0] quo_d;
  logic [31:0] ratio, cx, cy, hx, hy;
  logic signed [63:0] px, py;

  // One digit of the bitwise square root, plus the divider step and the correction terms.
  always_comb begin
    sqSum_d  = ({{32{dx_q[31]}}, dx_q} * {{32{dx_q[31]}}, dx_q})
             + ({{32{dy_q[31]}}, dy_q} * {{32{dy_q[31]}}, dy_q});
    remShift = {sqRem_q, sqSrc_q[63:62]};
    trial    = {2'b00, sqRoot_q, 2'b01};
    sqRem_d  = remShift;
    sqRoot_d = {sqRoot_q[30:0], 1'b0};
    if (remShift >= trial) begin
      sqRem_d  = remShift - trial;
      sqRoot_d = {sqRoot_q[30:0], 1'b1};
    end
    diff = {1'b0, sqRoot_d} - {1'b0, REST_LEN};
    mag  = diff[32] ? (33'd0 - diff) : diff;
    divRem_d = divRem_q;
    quo_d    = {quo_q[14:0], 1'b0};
    if (divRem_q >= divDen_q) begin
      divRem_d = divRem_q - divDen_q;
      quo_d    = {quo_q[14:0], 1'b1};
    end
    if (dZero_q)      ratio = 32'd0;
    else if (clamp_q) ratio = 32'd0 - (32'd1 << FRAC);
    else if (neg_q)   ratio = 32'd0 - {16'd0, quo_q};
    else              ratio = {16'd0, quo_q};
    px = {{32{dx_q[31]}}, dx_q} * {{32{ratio[31]}}, ratio};
    py = {{32{dy_q[31]}}, dy_q} * {{32{ratio[31]}}, ratio};
    cx = 32'(px >>> FRAC);
    cy = 32'(py >>> FRAC);
    hx = {cx[31], cx[31:1]};
    hy = {cy[31], cy[31:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pinA_q   <= 1'b0;
      pinB_q   <= 1'b0;
      xa_q     <= '0;
      ya_q     <= '0;
      xb_q     <= '0;
      yb_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sqSrc_q  <= '0;
      sqRem_q  <= '0;
      sqRoot_q <= '0;
      divRem_q <= '0;
      divDen_q <= '0;
      quo_q    <= '0;
      neg_q    <= 1'b0;
      dZero_q  <= 1'b0;
      clamp_q  <= 1'b0;
      xaFix_q  <= '0;
      yaFix_q  <= '0;
      xbFix_q  <= '0;
      ybFix_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            xa_q    <= xa_i;
            ya_q    <= ya_i;
            xb_q    <= xb_i;
            yb_q    <= yb_i;
            pinA_q  <= pin_a_i;
            pinB_q  <= pin_b_i;
            busy_q  <= 1'b1;
            state_q <= DELTA;
          end
        end
        DELTA: begin
          dx_q    <= xb_q - xa_q;
          dy_q    <= yb_q - ya_q;
          state_q <= SQSUM;
        end
        SQSUM: begin
          sqSrc_q  <= sqSum_d;
          sqRem_q  <= '0;
          sqRoot_q <= '0;
          cnt_q    <= '0;
          state_q  <= SQRT;
        end
        SQRT: begin
          sqSrc_q  <= {sqSrc_q[61:0], 2'b00};
          sqRem_q  <= 34'(sqRem_d);
          sqRoot_q <= sqRoot_d;
          cnt_q    <= cnt_q + 5'd1;
          // Last root digit: seed the divider with |d - REST_LEN| and the special-case flags.
          if (cnt_q == 5'd31) begin
            divRem_q <= {31'd0, mag} << FRAC;
            divDen_q <= {32'd0, sqRoot_d} << (DIV_ITERS - 1);
            quo_q    <= '0;
            neg_q    <= diff[32];
            dZero_q  <= (sqRoot_d == 32'd0);
            clamp_q  <= ({sqRoot_d, 1'b0} <= {1'b0, REST_LEN});
            cnt_q    <= '0;
            state_q  <= DIV;
          end
        end
        DIV: begin
          divRem_q <= divRem_d;
          divDen_q <= {1'b0, divDen_q[63:1]};
          quo_q    <= quo_d;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_ITERS - 1)) state_q <= APPLY;
        end
        APPLY: begin
          case ({pinA_q, pinB_q})
            2'b00: begin
              xaFix_q <= xa_q + hx;
              yaFix_q <= ya_q + hy;
              xbFix_q <= xb_q - hx;
              ybFix_q <= yb_q - hy;
            end
            2'b10: begin
              xaFix_q <= xa_q;
              yaFix_q <= ya_q;
              xbFix_q <= xb_q - cx;
              ybFix_q <= yb_q - cy;
            end
            2'b01: begin
              xaFix_q <= xa_q + cx;
              yaFix_q <= ya_q + cy;
              xbFix_q <= xb_q;
              ybFix_q <= yb_q;
            end
            default: begin
              xaFix_q <= xa_q;
              yaFix_q <= ya_q;
              xbFix_q <= xb_q;
              ybFix_q <= yb_q;
            end
          endcase
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign xa_fix_o = xaFix_q;
  assign ya_fix_o = yaFix_q;
  assign xb_fix_o = xbFix_q;
  assign yb_fix_o = ybFix_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_distance_constraint_solver.sv
// Directed bench for distance_constraint_solver: hand-computed Q20.12 results,
// fixed 51-cycle latency, ignored start while busy, and reset mid-solve.
module tb_distance_constraint_solver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, pin_a_i, pin_b_i;
  logic [31:0] xa_i, ya_i, xb_i, yb_i;
  logic [31:0] xa_fix_o, ya_fix_o, xb_fix_o, yb_fix_o;
  logic        busy_o, done_o;
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  int          extra;

  distance_constraint_solver dut (
    .clk(clk), .reset(reset), .start_i(start_i), .pin_a_i(pin_a_i), .pin_b_i(pin_b_i),
    .xa_i(xa_i), .ya_i(ya_i), .xb_i(xb_i), .yb_i(yb_i),
    .xa_fix_o(xa_fix_o), .ya_fix_o(ya_fix_o), .xb_fix_o(xb_fix_o), .yb_fix_o(yb_fix_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns at the falling edge after the accepting edge.
  task automatic applyStimulus(input logic [31:0] ax, ay, bx, by, input logic pa, pb);
    @(negedge clk);
    xa_i = ax; ya_i = ay; xb_i = bx; yb_i = by;
    pin_a_i = pa; pin_b_i = pb; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (done_o !== 1'b1 && n < 80) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic runSolve(input string tag, input logic [31:0] ax, ay, bx, by,
                          input logic pa, pb, input logic [31:0] ex0, ey0, ex1, ey1);
    int n;
    applyStimulus(ax, ay, bx, by, pa, pb);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd1);
    waitDone(n);
    checkOutput({tag, "_latency"}, 32'(n), 32'd51);
    checkOutput({tag, "_xa"}, xa_fix_o, ex0);
    checkOutput({tag, "_ya"}, ya_fix_o, ey0);
    checkOutput({tag, "_xb"}, xb_fix_o, ex1);
    checkOutput({tag, "_yb"}, yb_fix_o, ey1);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_donepulse"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_busyend"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_hold"}, yb_fix_o, ey1);
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; pin_a_i = 1'b0; pin_b_i = 1'b0;
    xa_i = '0; ya_i = '0; xb_i = '0; yb_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_xa", xa_fix_o, 32'h0);
    checkOutput("rst_ya", ya_fix_o, 32'h0);
    checkOutput("rst_xb", xb_fix_o, 32'h0);
    checkOutput("rst_yb", yb_fix_o, 32'h0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);

    runSolve("stretch", 32'h000C8000, 32'h0, 32'h000C8000, 32'hFFFEC000, 1'b0, 1'b0,
             32'h000C8000, 32'hFFFFB000, 32'h000C8000, 32'hFFFF1000);
    runSolve("pinA", 32'h000C8000, 32'h0, 32'h000C8000, 32'hFFFEC000, 1'b1, 1'b0,
             32'h000C8000, 32'h0, 32'h000C8000, 32'hFFFF6000);
    runSolve("pinB", 32'h000C8000, 32'h0, 32'h000C8000, 32'hFFFEC000, 1'b0, 1'b1,
             32'h000C8000, 32'hFFFF6000, 32'h000C8000, 32'hFFFEC000);
    runSolve("diag", 32'h0, 32'h0, 32'h0000C000, 32'h00010000, 1'b0, 1'b0,
             32'h00003000, 32'h00004000, 32'h00009000, 32'h0000C000);
    runSolve("bothpin", 32'h0, 32'h0, 32'h0000C000, 32'h00010000, 1'b1, 1'b1,
             32'h0, 32'h0, 32'h0000C000, 32'h00010000);
    runSolve("compress", 32'h00002000, 32'h0, 32'h00002000, 32'hFFFF8000, 1'b0, 1'b0,
             32'h00002000, 32'h00001000, 32'h00002000, 32'hFFFF7000);
    runSolve("clamp", 32'h00002000, 32'h0, 32'h00002000, 32'hFFFFC000, 1'b0, 1'b0,
             32'h00002000, 32'h00002000, 32'h00002000, 32'hFFFFA000);
    runSolve("coincident", 32'h00005000, 32'hFFFFD000, 32'h00005000, 32'hFFFFD000, 1'b0, 1'b0,
             32'h00005000, 32'hFFFFD000, 32'h00005000, 32'hFFFFD000);

    $display("[TB] start while busy, inputs changed mid-solve");
    applyStimulus(32'h000C8000, 32'h0, 32'h000C8000, 32'hFFFEC000, 1'b0, 1'b0);
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 80) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 10) begin
        start_i = 1'b1; xa_i = 32'h0; ya_i = 32'h0; xb_i = 32'h0000C000; yb_i = 32'h00010000;
      end else begin
        start_i = 1'b0;
      end
    end
    checkOutput("ign_latency", 32'(cyc), 32'd51);
    checkOutput("ign_ya", ya_fix_o, 32'hFFFFB000);
    checkOutput("ign_yb", yb_fix_o, 32'hFFFF1000);
    checkOutput("ign_xb", xb_fix_o, 32'h000C8000);
    extra = 0;
    repeat (70) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o === 1'b1) extra++;
    end
    checkOutput("ign_extra_done", 32'(extra), 32'd0);

    $display("[TB] reset mid-solve");
    applyStimulus(32'h0, 32'h0, 32'h0000C000, 32'h00010000, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_rst_ya", ya_fix_o, 32'h0);
    checkOutput("mid_rst_yb", yb_fix_o, 32'h0);
    checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
    extra = 0;
    repeat (60) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o === 1'b1) extra++;
    end
    checkOutput("mid_rst_no_done", 32'(extra), 32'd0);
    runSolve("after_rst", 32'h0, 32'h0, 32'h0000C000, 32'h00010000, 1'b0, 1'b0,
             32'h00003000, 32'h00004000, 32'h00009000, 32'h0000C000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/distance_constraint_solver.md
Name: distance_constraint_solver

Overview:
Computes the fix-constraint positions for one rope segment: two adjacent chain nodes A and B joined by a fixed rest length. Sits upstream of the node position registers. The simulation sequencer starts it during the fix-constraint phase, and its outputs drive the nodes' x/y fix-constraint inputs. It uses a multi-cycle iterative square root and divider, runs with fixed latency, and has a start/busy/done handshake.

Parameters:
REST_LEN, 32'h0000A000, segment rest length in signed Q20.12 (10.0)
FRAC, 12, number of fractional bits. The block is only required to work at 12.

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  request a solve; sampled only in IDLE
pin_a  in  1  node A is fixed (anchor); sampled with start
pin_b  in  1  node B is fixed; sampled with start
xa  in  32  node A x, signed Q20.12
ya  in  32  node A y
xb  in  32  node B x
yb  in  32  node B y
xa_fix  out  32  corrected A x
ya_fix  out  32  corrected A y
xb_fix  out  32  corrected B x
yb_fix  out  32  corrected B y
busy  out  1  solve in progress
done  out  1  one-cycle pulse; outputs valid

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset state: FSM goes to IDLE. All four *_fix outputs, busy and done are 0. Reset mid-solve aborts the solve, and no done is produced.
- Arithmetic: all values are signed Q20.12. A product is the 64-bit signed product arithmetically shifted right by 12 and truncated to 32 bits. Inputs are guaranteed within ±2^18, so deltas do not overflow 32 bits.
- FSM states: IDLE, DELTA, SQSUM, SQRT, DIV, APPLY.
- IDLE:
  - start=1 at edge N: latch xa, ya, xb, yb, pin_a, pin_b; busy<=1; go to DELTA.
  - start=0: stay.
- DELTA (edge N+1): dx = xb−xa, dy = yb−ya.
- SQSUM (edge N+2): s = dx² + dy² as a 64-bit unsigned value.
- SQRT (edges N+3..N+34): 32-iteration bitwise integer square root. d = floor(sqrt(s)) is directly Q20.12.
- DIV (edges N+35..N+50): 16-iteration restoring division. ratio = ((d−REST_LEN) << 12) / d, truncated toward zero, with sign applied after magnitude division. Special cases:
  - d == 0: ratio = 0.
  - 2·d <= REST_LEN: ratio clamped to −1.0 (32'hFFFFF000). The division result is ignored.
- APPLY (edge N+51): cx = dx·ratio, cy = dy·ratio. Write outputs, set done<=1 and busy<=0, return to IDLE.
  - Neither pinned: hx = cx>>>1, hy = cy>>>1. A += (hx, hy); B −= (hx, hy).
  - pin_a only: A unchanged; B −= (cx, cy).
  - pin_b only: B unchanged; A += (cx, cy).
  - Both pinned: outputs = latched inputs.
- Latency is exactly 51 cycles for every input, including the d == 0 and clamp cases. done is high only in the cycle after edge N+51.
- busy is high from edge N through edge N+50.
- start while busy is ignored and not queued. start is accepted again in the cycle done is high, so back-to-back solves have a period of 52 cycles.
- *_fix outputs hold their values until the next APPLY. Changing inputs mid-solve has no effect.

Test Plan:
- Reset, then idle → all outputs 0, busy=0, done=0.
- Stretched segment, no pins. A=(200.0, 0)=(0xC8000, 0), B=(0xC8000, 0xFFFEC000) i.e. y=−20.0. → done exactly 51 cycles after start, ya_fix=0xFFFFB000 (−5.0), yb_fix=0xFFFF1000 (−15.0), x outputs = 0xC8000.
- Same inputs with pin_a=1 → A unchanged; yb_fix=0xFFFF6000 (−10.0).
- Diagonal segment: A=(0, 0), B=(12.0, 16.0). d=20, ratio 0.5 → A=(0x3000, 0x4000), B=(0x9000, 0xC000).
- Compressed segment: A y=0, B y=−8.0, same x. ratio=0xFFFFFC00 → ya_fix=0x1000, yb_fix=0xFFFF7000. Clamp case with B y=−4.0 → ya_fix=0x2000, yb_fix=0xFFFFA000.
- Coincident nodes (d=0) → outputs equal inputs, latency still 51.
- start pulsed at cycle 10 of a solve → ignored, single done.
- Reset at cycle 20 → no done, outputs 0, next start works normally.
